// File: rtl/guess_game_ctrl.sv
// ============================================================================
// Module   : guess_game_ctrl
// Purpose  : Number-guessing game sequencer: target latch, BCD guess check,
//            attempt counting and win/lose decision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_game_ctrl #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             submit_N,
  input  logic             submit_guess,
  input  logic             new_game,
  input  logic [16:0]      nvalue,
  input  logic [16:0]      guess_in,
  output logic [2:0]       state,
  output logic [1:0]       hint,
  output logic [TRY_W-1:0] tries,
  output logic             err,
  output logic             win,
  output logic             lose,
  output logic [16:0]      target_out
);

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam logic [TRY_W-1:0] c_max_tries = TRY_W'(MAX_TRIES);
  localparam logic [1:0]       c_hint_none = 2'b00;
  localparam logic [1:0]       c_hint_low  = 2'b01;
  localparam logic [1:0]       c_hint_high = 2'b10;
  localparam logic [1:0]       c_hint_hit  = 2'b11;

  // Bit 16 is the ten-thousands digit and may be 0 or 1 freely.
  function automatic logic f_bcd_ok(input logic [16:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  state_t           r_state, w_state_nxt;
  logic [16:0]      r_target, w_target_nxt;
  logic [16:0]      r_guess, w_guess_nxt;
  logic [TRY_W-1:0] r_tries, w_tries_nxt;
  logic [1:0]       r_hint, w_hint_nxt;
  logic             r_err, w_err_nxt;
  logic             r_win, r_lose;
  logic             r_hist_n, r_hist_guess, r_hist_new;

  logic             w_ev_n, w_ev_guess, w_ev_new;
  logic [TRY_W-1:0] w_tries_inc;

  assign w_ev_n      = r_hist_n     & ~submit_N;
  assign w_ev_guess  = r_hist_guess & ~submit_guess;
  assign w_ev_new    = r_hist_new   & ~new_game;
  assign w_tries_inc = r_tries + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_guess_nxt  = r_guess;
    w_tries_nxt  = r_tries;
    w_hint_nxt   = r_hint;
    w_err_nxt    = 1'b0;

    case (r_state)
      ST_ARM: begin
        if (w_ev_new) begin
          w_tries_nxt = '0;
          w_hint_nxt  = c_hint_none;
        end else if (w_ev_n) begin
          if (f_bcd_ok(nvalue)) begin
            w_target_nxt = nvalue;
            w_tries_nxt  = '0;
            w_hint_nxt   = c_hint_none;
            w_state_nxt  = ST_PLAY;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (w_ev_new) begin
          w_tries_nxt = '0;
          w_hint_nxt  = c_hint_none;
          w_state_nxt = ST_ARM;
        end else if (w_ev_guess) begin
          if (f_bcd_ok(guess_in)) begin
            w_guess_nxt = guess_in;
            w_state_nxt = ST_CHECK;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      // Single-cycle evaluation; button events seen here are dropped.
      ST_CHECK: begin
        if (r_tries < c_max_tries) begin
          w_tries_nxt = w_tries_inc;
        end
        if (r_guess == r_target) begin
          w_hint_nxt  = c_hint_hit;
          w_state_nxt = ST_WIN;
        end else begin
          w_hint_nxt  = (r_guess < r_target) ? c_hint_low : c_hint_high;
          w_state_nxt = (w_tries_inc == c_max_tries) ? ST_LOSE : ST_PLAY;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (w_ev_new) begin
          w_tries_nxt = '0;
          w_hint_nxt  = c_hint_none;
          w_state_nxt = ST_ARM;
        end
      end

      default: begin
        w_tries_nxt = '0;
        w_hint_nxt  = c_hint_none;
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ARM;
      r_target     <= '0;
      r_guess      <= '0;
      r_tries      <= '0;
      r_hint       <= c_hint_none;
      r_err        <= 1'b0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_hist_n     <= 1'b1;
      r_hist_guess <= 1'b1;
      r_hist_new   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_guess      <= w_guess_nxt;
      r_tries      <= w_tries_nxt;
      r_hint       <= w_hint_nxt;
      r_err        <= w_err_nxt;
      r_win        <= (w_state_nxt == ST_WIN);
      r_lose       <= (w_state_nxt == ST_LOSE);
      r_hist_n     <= submit_N;
      r_hist_guess <= submit_guess;
      r_hist_new   <= new_game;
    end
  end

  assign state      = r_state;
  assign hint       = r_hint;
  assign tries      = r_tries;
  assign err        = r_err;
  assign win        = r_win;
  assign lose       = r_lose;
  assign target_out = ((r_state == ST_WIN) || (r_state == ST_LOSE)) ? r_target : 17'd0;

endmodule

`default_nettype wire
